// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
//
// Shared CPU-wide definitions:
//   state_t              - 2-bit fetch-unit state encoding
//   DEFAULT_RESET_VECTOR - boot address of the first fetch after reset
//   DEFAULT_HALT_ADDR    - redirect target that terminates execution
//   opcode_t             - primary opcode field (instr[31:26]) of the MIPS-I ISA
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BLEZ    = 6'h06,
        OP_BGTZ    = 6'h07,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LB      = 6'h20,
        OP_LH      = 6'h21,
        OP_LWL     = 6'h22,
        OP_LW      = 6'h23,
        OP_LBU     = 6'h24,
        OP_LHU     = 6'h25,
        OP_LWR     = 6'h26,
        OP_SB      = 6'h28,
        OP_SH      = 6'h29,
        OP_SWL     = 6'h2A,
        OP_SW      = 6'h2B,
        OP_SWR     = 6'h2E
    } opcode_t;

endpackage

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
//
// Instruction fetch for a MIPS core with one architectural branch delay slot.
// Each instruction is requested from instruction memory, captured, and held
// for the downstream stage until it is accepted; then the next PC is fetched.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   clk_enable            - 0 freezes every register (outputs hold)
//   active                - 1 until a redirect to HALT_ADDR has completed
//   instr_address/_read   - fetch request to instruction memory
//   instr_waitrequest     - memory stall; instr_readdata valid when low
//   instr_readdata        - instruction word from memory
//   instr_out/_pc/_valid  - captured instruction, its address, valid flag
//   instr_ready           - downstream accept
//   br_valid, br_target   - taken branch/jump redirect from execute
module mips_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    output logic        active,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [31:0] br_target
);

    // Branch targets are word addresses; the low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

    state_t      state_p0;
    logic [31:0] pc_p0;
    logic        pending_p0;
    logic [31:0] target_p0;
    logic [31:0] word_p1;
    logic [31:0] wpc_p1;

    logic        handshake;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        halt_now;
    logic        br_capture;

    always_comb begin
        handshake   = (state_p0 == ST_HOLD) & instr_ready & clk_enable;
        // A redirect applies at a handshake if one is already pending, or if
        // the branch arrives in the very cycle of the delay-slot handshake.
        // A pending target always beats a fresh br_valid.
        redirect    = pending_p0 | br_valid;
        redirect_pc = pending_p0 ? target_p0 : align_word(br_target);
        next_pc     = redirect ? redirect_pc : (pc_p0 + 32'd4);
        halt_now    = redirect & (redirect_pc == HALT_ADDR);
        // Branches outside the handshake cycle are remembered until the
        // delay slot is accepted; later ones are dropped while pending.
        br_capture  = br_valid & ~pending_p0 & ~handshake & (state_p0 != ST_HALTED);
    end

    // Stage p0: fetch PC, FSM and redirect bookkeeping.
    // Stage p1: captured instruction word and its PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0   <= ST_FETCH;
            pc_p0      <= RESET_VECTOR;
            pending_p0 <= 1'b0;
            target_p0  <= 32'd0;
            word_p1    <= 32'd0;
            wpc_p1     <= 32'd0;
        end else if (clk_enable) begin
            case (state_p0)
                ST_FETCH, ST_WAIT: begin
                    if (!instr_waitrequest) begin
                        word_p1  <= instr_readdata;
                        wpc_p1   <= pc_p0;
                        state_p0 <= ST_HOLD;
                    end else begin
                        state_p0 <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        pc_p0      <= next_pc;
                        pending_p0 <= 1'b0;
                        state_p0   <= halt_now ? ST_HALTED : ST_FETCH;
                    end
                end
                default: begin
                    state_p0 <= ST_HALTED;
                end
            endcase

            if (br_capture) begin
                pending_p0 <= 1'b1;
                target_p0  <= align_word(br_target);
            end
        end
    end

    // Outputs decode from state; reset forces the idle/cleared view in the
    // reset cycle itself rather than one cycle later.
    assign active        = reset | (state_p0 != ST_HALTED);
    assign instr_read    = ~reset & ((state_p0 == ST_FETCH) | (state_p0 == ST_WAIT));
    assign instr_valid   = ~reset & (state_p0 == ST_HOLD);
    assign instr_address = pc_p0;
    assign instr_out     = reset ? 32'd0 : word_p1;
    assign instr_pc      = reset ? 32'd0 : wpc_p1;

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'hBFC00000, address of first fetch after reset.
REQ-002 Parameter HALT_ADDR, 32'h00000000, redirect target that terminates execution.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clk_enable  in  1  0 freezes all state; outputs hold their values.
REQ-006 active  out  1  1 from reset until halt completes.
REQ-007 instr_address  out  32  current fetch PC.
REQ-008 instr_read  out  1  fetch request to instruction memory.
REQ-009 instr_waitrequest  in  1  1 means the memory has not yet returned instr_readdata.
REQ-010 instr_readdata  in  32  instruction word, valid when instr_read=1 and instr_waitrequest=0.
REQ-011 instr_out  out  32  fetched instruction presented downstream.
REQ-012 instr_pc  out  32  address of instr_out.
REQ-013 instr_valid  out  1  instr_out/instr_pc valid.
REQ-014 instr_ready  in  1  downstream accepts; handshake = instr_valid & instr_ready & clk_enable.
REQ-015 br_valid  in  1  taken branch/jump request from execute.
REQ-016 br_target  in  32  redirect address, sampled with br_valid.

Function
REQ-017 States FETCH, WAIT, HOLD, HALTED; all transitions occur only when clk_enable=1.
REQ-018 FETCH: instr_read=1, instr_address=pc; waitrequest=0 -> latch readdata into instr_out, pc into instr_pc, go to HOLD; waitrequest=1 -> go to WAIT.
REQ-019 WAIT: instr_read=1, address held; leave to HOLD on first cycle with waitrequest=0 (capture as in REQ-018).
REQ-020 HOLD: instr_read=0, instr_valid=1, instr_out/instr_pc stable until handshake; on handshake go to FETCH with pc updated per REQ-021/022.
REQ-021 Sequential update: pc <= pc + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-022 Branch delay slot: br_valid sets pending=1 and latches br_target; the first handshake in or after that cycle is the delay slot; at that handshake pc <= target and pending clears.
REQ-023 br_valid in the same cycle as a handshake: that handshake is the delay slot; pc <= br_target directly.
REQ-024 br_valid while pending=1: ignored; the first target wins.
REQ-025 Delay-slot handshake with target == HALT_ADDR: go to HALTED instead of FETCH.
REQ-026 HALTED: active=0, instr_read=0, instr_valid=0; br_valid ignored; exit only by reset.
REQ-027 instr_valid=1 only in HOLD; minimum fetch-to-valid latency is 1 cycle; throughput is at most one instruction per 2 cycles.
REQ-028 Misaligned br_target: bits [1:0] forced to 0 on latch.

Reset
REQ-029 In the reset cycle: pc=RESET_VECTOR, state=FETCH, pending=0, active=1, instr_valid=0, instr_read=0, instr_out=0, instr_pc=0.
REQ-030 Reset takes priority over clk_enable and abandons any in-flight fetch, pending redirect or HALTED state.

Structure
REQ-031 Package mips_cpu_pkg holds the fetch state_t enum (2-bit) and the default RESET_VECTOR and HALT_ADDR constants; the existing CPU opcode_t moves there too.
REQ-032 No sub-module; single module, target 150-250 lines of RTL.

Verification
REQ-033 Reset, waitrequest=0, ready=1: instr_address sequence BFC00000, BFC00004, BFC00008; instr_valid pulses every 2nd cycle.
REQ-034 waitrequest high 3 cycles on first fetch: instr_address held at BFC00000 for 4 cycles; instr_valid rises the cycle after waitrequest falls.
REQ-035 br_valid with target 0x00001000 after accepting BFC00000: BFC00004 (delay slot) is fetched and accepted, then the next fetch is 0x00001000.
REQ-036 ready held low 5 cycles in HOLD: instr_out stable, no new fetch; one handshake on release; br_valid coincident with that handshake redirects immediately.
REQ-037 br_valid target 0: delay slot accepted, then active=0, instr_read=0 permanently; reset restarts at BFC00000 with active=1.
REQ-038 clk_enable=0 for 3 cycles mid-WAIT and mid-HOLD: all outputs frozen; sequence resumes unchanged.
